// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if : read, write, reserve and clear bus of the multi-port regfile
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int NUM_REGS = 8,
    parameter int DATAW    = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*DATAW-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic                    wr0_en;
    logic [AW-1:0]           wr0_addr;
    logic [DATAW/8-1:0]      wr0_be;
    logic [DATAW-1:0]        wr0_data;
    logic                    wr1_en;
    logic [AW-1:0]           wr1_addr;
    logic [DATAW/8-1:0]      wr1_be;
    logic [DATAW-1:0]        wr1_data;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic                    clr_req;
    logic                    clr_busy;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_be, wr0_data,
               wr1_en, wr1_addr, wr1_be, wr1_data, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_be, wr0_data,
               wr1_en, wr1_addr, wr1_be, wr1_data, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, clr_busy
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : multi-port register file, byte-enabled dual write, bypass,
//              busy scoreboard and sequential bulk-clear engine
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int NUM_REGS = 8,
    parameter int DATAW    = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int NB = DATAW / 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DATAW-1:0]    regs_q [NUM_REGS];
    logic [DATAW-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [DATAW-1:0]    w_merged [NUM_REGS];
    logic [NUM_REGS-1:0] w_hit;
    logic                w_idle, w_wr0, w_wr1, w_rsv;

    // Writes and reservations are only live outside a sweep; reg 0 drops them when hardwired
    assign w_idle = (state_q == S_IDLE);
    assign w_wr0  = w_idle & bus.wr0_en & ~((ZERO_REG != 0) && (bus.wr0_addr == '0));
    assign w_wr1  = w_idle & bus.wr1_en & ~((ZERO_REG != 0) && (bus.wr1_addr == '0));
    assign w_rsv  = w_idle & bus.rsv_en & ~((ZERO_REG != 0) && (bus.rsv_addr == '0));

    always_comb begin
        w_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_merged[r] = regs_q[r];
            w_hit[r]    = (w_wr0 && (bus.wr0_addr == AW'(r))) ||
                          (w_wr1 && (bus.wr1_addr == AW'(r)));
            for (int b = 0; b < NB; b++) begin
                if (w_wr1 && (bus.wr1_addr == AW'(r)) && bus.wr1_be[b])
                    w_merged[r][b*8 +: 8] = bus.wr1_data[b*8 +: 8];
                else if (w_wr0 && (bus.wr0_addr == AW'(r)) && bus.wr0_be[b])
                    w_merged[r][b*8 +: 8] = bus.wr0_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    state_d = S_SWEEP;
                    ptr_d   = '0;
                end
            end
            S_SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(NUM_REGS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // New producer wins: a reservation overrides a same-cycle write release
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = w_merged[r];
            busy_d[r] = (busy_q[r] & ~w_hit[r]) | (w_rsv && (bus.rsv_addr == AW'(r)));
        end
        if (!w_idle) begin
            regs_d[ptr_q] = '0;
            busy_d[ptr_q] = 1'b0;
        end
    end

    logic [NUM_RD*DATAW-1:0] w_rd_data;
    logic [NUM_RD-1:0]       w_rd_busy;
    logic [AW-1:0]           w_a;
    logic                    w_byp;

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_a       = '0;
        w_byp     = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_a   = bus.rd_addr[k*AW +: AW];
            w_byp = (BYPASS != 0) && w_hit[w_a];
            w_rd_data[k*DATAW +: DATAW] = w_byp ? w_merged[w_a] : regs_q[w_a];
            w_rd_busy[k] = busy_q[w_a] & ~w_byp;
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.clr_busy = (state_q == S_SWEEP);

endmodule

`default_nettype wire
